// File: rtl/ultrasonic_echo_meter_if.sv
// Measurement result bus from ultrasonic_echo_meter to its consumer (buzzer_control).
// Latency: none (wires only); backpressure: none, the consumer must take each valid strobe.
interface ultrasonic_echo_meter_if;
  logic [23:0] value;
  logic        valid;
  logic        timeout;

  modport master (output value, output valid, output timeout);
  modport slave  (input  value, input  valid, input  timeout);
endinterface

// File: rtl/ultrasonic_echo_meter.sv
// Periodic ultrasonic trigger plus echo-width timer; optional median-of-3 filter under ECHO_MEDIAN3_EN.
// Latency: echo-to-FSM is 2 cycles, result strobe 1 cycle after completion (+1 with median); no backpressure.
module ultrasonic_echo_meter #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1250000,
  parameter int PERIOD_CYCLES  = 3000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      echo,
  output logic                      trig,
  output logic                      busy,
  ultrasonic_echo_meter_if.master   res
);

  localparam int          PW         = $clog2(PERIOD_CYCLES + 1);
  localparam logic [23:0] TRIG_LAST  = 24'(TRIG_CYCLES - 1);
  localparam logic [23:0] WAIT_LAST  = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] MEAS_SAT   = 24'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   cnt_q, cnt_d;
  logic [PW-1:0] pcnt_q;
  logic          pcnt_clr;
  logic          echo_m, echo_s;

  logic          raw_vld;
  logic          raw_to;
  logic [23:0]   raw_val;

  logic [23:0]   value_q;
  logic          valid_q;
  logic          timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_m <= 1'b0;
      echo_s <= 1'b0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One shared counter: trigger width, rise wait, then echo width.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcnt_clr = 1'b0;
    raw_vld  = 1'b0;
    raw_to   = 1'b0;
    raw_val  = '0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d  = TRIG;
          cnt_d    = '0;
          pcnt_clr = 1'b1;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      WAIT_RISE: begin
        if (echo_s) begin
          state_d = MEASURE;
          cnt_d   = 24'd1;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          raw_vld = 1'b1;
          raw_to  = 1'b1;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          raw_vld = 1'b1;
          raw_val = cnt_q;
        end else if (cnt_q == MEAS_SAT) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
          raw_vld = 1'b1;
          raw_to  = 1'b1;
          raw_val = MEAS_SAT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      HOLDOFF: begin
        // A late-falling echo defers the next trigger past the period.
        if (!echo_s && (pcnt_q == PER_LAST)) begin
          cnt_d = '0;
          if (en) begin
            state_d  = TRIG;
            pcnt_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (pcnt_clr) begin
      pcnt_q <= '0;
    end else if (pcnt_q != PER_LAST) begin
      pcnt_q <= pcnt_q + PW'(1);
    end
  end

  assign trig = (state_q == TRIG);
  assign busy = (state_q == TRIG) || (state_q == WAIT_RISE) || (state_q == MEASURE);

`ifdef ECHO_MEDIAN3_EN
  logic [23:0] hist0, hist1, hist2;
  logic [1:0]  nres;
  logic        pend;
  logic        pend_to;

  function automatic logic [23:0] med3(input logic [23:0] a, input logic [23:0] b,
                                       input logic [23:0] c);
    logic [23:0] lo, hi, mid;
    lo  = (a < b) ? a : b;
    hi  = (a < b) ? b : a;
    mid = (hi < c) ? hi : c;
    return (lo > mid) ? lo : mid;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0   <= '0;
      hist1   <= '0;
      hist2   <= '0;
      nres    <= 2'd0;
      pend    <= 1'b0;
      pend_to <= 1'b0;
    end else begin
      pend <= raw_vld;
      if (raw_vld) begin
        hist0   <= raw_val;
        hist1   <= hist0;
        hist2   <= hist1;
        pend_to <= raw_to;
        if (nres != 2'd3) nres <= nres + 2'd1;
      end
    end
  end

  // Until three results exist, the newest one passes through unfiltered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= pend;
      if (pend) begin
        value_q   <= (nres == 2'd3) ? med3(hist0, hist1, hist2) : hist0;
        timeout_q <= pend_to;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= raw_vld;
      if (raw_vld) begin
        value_q   <= raw_val;
        timeout_q <= raw_to;
      end
    end
  end
`endif

  assign res.value   = value_q;
  assign res.valid   = valid_q;
  assign res.timeout = timeout_q;

endmodule
